// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : timer_bank
// Purpose  : NUM_CH down-counting timers (one-shot / auto-reload) with sticky,
//            maskable W1C interrupts. Optional macro: TIMER_PRESCALE_EN.
// Revision : 1.0
// ============================================================================
module timer_bank #(
  parameter int          NUM_CH    = 2,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h7F00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  localparam int          c_ch_w     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] c_end_addr = BASE_ADDR + 32'(16 * NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  logic [31:0]          w_addr;
  logic [31:0]          w_off;
  logic                 w_hit;
  logic [c_ch_w-1:0]    w_ch;
  logic [1:0]           w_reg;
  logic [32*NUM_CH-1:0] w_ctrl_rd;
  logic [32*NUM_CH-1:0] w_preset_rd;
  logic [32*NUM_CH-1:0] w_count_rd;
  logic [32*NUM_CH-1:0] w_presc_rd;
  logic                 w_unused;

  assign w_addr   = {addr[31:2], 2'b00};
  assign w_hit    = (w_addr >= BASE_ADDR) && (w_addr < c_end_addr);
  assign w_off    = w_addr - BASE_ADDR;
  assign w_ch     = w_off[4 +: c_ch_w];
  assign w_reg    = w_off[3:2];
  assign w_unused = ^{addr[1:0], wdata, w_off};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             w_sel, w_wr_ctrl, w_wr_preset, w_tick;
    logic             en_q, en_d, mode_q, mode_d, im_q, im_d, pend_q, pend_d;
    logic [CNT_W-1:0] preset_q, preset_d, count_q, count_d;
    logic [31:0]      w_preset_ext, w_count_ext;
    state_t           state_q, state_d;

    assign w_sel       = w_hit && we && (w_ch == c_ch_w'(i));
    assign w_wr_ctrl   = w_sel && (w_reg == 2'd0);
    assign w_wr_preset = w_sel && (w_reg == 2'd1);

`ifdef TIMER_PRESCALE_EN
    logic       w_wr_presc;
    logic [7:0] presc_q, presc_d, pscnt_q, pscnt_d;
    assign w_wr_presc = w_sel && (w_reg == 2'd3);
    assign w_tick     = (pscnt_q == presc_q);
    assign w_presc_rd[32*i +: 32] = {24'd0, presc_q};
`else
    assign w_tick     = 1'b1;
    assign w_presc_rd[32*i +: 32] = 32'd0;
`endif

    always_comb begin
      en_d     = en_q;
      mode_d   = mode_q;
      im_d     = im_q;
      pend_d   = pend_q;
      preset_d = preset_q;
      count_d  = count_q;
      state_d  = state_q;
      if (w_wr_ctrl) begin
        en_d   = wdata[0];
        mode_d = wdata[1];
        im_d   = wdata[3];
        if (wdata[4]) pend_d = 1'b0;
      end
      if (w_wr_preset) preset_d = wdata[CNT_W-1:0];

      // The freshly written EN steers IDLE/CNT so a start takes effect next cycle
      case (state_q)
        S_IDLE: if (en_d) state_d = S_LOAD;
        S_LOAD: begin
          count_d = preset_q;
          state_d = (preset_q == '0) ? S_INT : S_CNT;
        end
        S_CNT: begin
          if (!en_d) begin
            state_d = S_IDLE;
          end else if (w_tick) begin
            if (count_q <= CNT_W'(1)) begin
              count_d = '0;
              state_d = S_INT;
            end else begin
              count_d = count_q - CNT_W'(1);
            end
          end
        end
        S_INT: begin
          pend_d = 1'b1;
          if (mode_q) begin
            state_d = S_LOAD;
          end else begin
            if (!(w_wr_ctrl && wdata[0])) en_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

`ifdef TIMER_PRESCALE_EN
    always_comb begin
      presc_d = presc_q;
      pscnt_d = pscnt_q;
      if (w_wr_presc) presc_d = wdata[7:0];
      if (state_q == S_LOAD) pscnt_d = 8'd0;
      else if ((state_q == S_CNT) && en_d) pscnt_d = w_tick ? 8'd0 : pscnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        presc_q <= 8'd0;
        pscnt_q <= 8'd0;
      end else begin
        presc_q <= presc_d;
        pscnt_q <= pscnt_d;
      end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        en_q     <= 1'b0;
        mode_q   <= 1'b0;
        im_q     <= 1'b0;
        pend_q   <= 1'b0;
        preset_q <= '0;
        count_q  <= '0;
        state_q  <= S_IDLE;
      end else begin
        en_q     <= en_d;
        mode_q   <= mode_d;
        im_q     <= im_d;
        pend_q   <= pend_d;
        preset_q <= preset_d;
        count_q  <= count_d;
        state_q  <= state_d;
      end
    end

    always_comb begin
      w_preset_ext = '0;
      w_count_ext  = '0;
      w_preset_ext[CNT_W-1:0] = preset_q;
      w_count_ext[CNT_W-1:0]  = count_q;
    end

    assign w_ctrl_rd[32*i +: 32]   = {27'd0, pend_q, im_q, 1'b0, mode_q, en_q};
    assign w_preset_rd[32*i +: 32] = w_preset_ext;
    assign w_count_rd[32*i +: 32]  = w_count_ext;
    assign irq[i]                  = pend_q & im_q;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_hit && (w_ch == c_ch_w'(i))) begin
        case (w_reg)
          2'd0:    rdata = w_ctrl_rd[32*i +: 32];
          2'd1:    rdata = w_preset_rd[32*i +: 32];
          2'd2:    rdata = w_count_rd[32*i +: 32];
          default: rdata = w_presc_rd[32*i +: 32];
        endcase
      end
    end
  end

  assign irq_any = |irq;

endmodule
`default_nettype wire
